// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Framed byte stream to 32-bit word RAM writer (LEN/ADR/DATA
//               blocks, LEN=0 terminates). Define CHECKSUM_EN to add a
//               per-block 32-bit additive checksum field.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_ADR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t c_BLK_END = S_CSUM;
`else
    localparam state_t c_BLK_END = S_LEN;
`endif
    localparam logic [AW-1:0] c_ADR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_bcnt;
    logic [23:0] r_field;
    logic [31:0] r_len;
    logic        r_busy;
    logic        w_accept;
    logic        w_last;
    logic [31:0] w_word;
`ifdef CHECKSUM_EN
    logic [31:0] r_csum;
`endif

    // Final byte of a field is combined directly with the three stored ones
    assign w_accept = rx_valid & rx_ready;
    assign w_last   = w_accept && (r_bcnt == 2'd3);
    assign w_word   = {rx_data, r_field};

    assign rx_ready = rst && ((r_state == S_LEN) || (r_state == S_ADR) ||
                              (r_state == S_DATA) || (r_state == S_CSUM));
    assign mem_we   = (r_state == S_WRITE);
    assign done     = (r_state == S_DONE);
    assign busy     = r_busy;
`ifdef CHECKSUM_EN
    assign err      = (r_state == S_ERR);
`else
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_LEN;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN:   if (w_last) w_next = (w_word == 32'd0) ? S_DONE : S_ADR;
            S_ADR:   if (w_last) w_next = S_DATA;
            S_DATA:  if (w_last) w_next = S_WRITE;
            S_WRITE: if (mem_ready) w_next = (r_len == 32'd1) ? c_BLK_END : S_DATA;
`ifdef CHECKSUM_EN
            S_CSUM:  if (w_last) w_next = (w_word == r_csum) ? S_LEN : S_ERR;
`endif
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcnt    <= 2'd0;
            r_field   <= 24'd0;
            r_len     <= 32'd0;
            r_busy    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= 32'd0;
`ifdef CHECKSUM_EN
            r_csum    <= 32'd0;
`endif
        end else begin
            if (w_accept) begin
                r_bcnt <= r_bcnt + 2'd1;
                case (r_bcnt)
                    2'd0:    r_field[7:0]   <= rx_data;
                    2'd1:    r_field[15:8]  <= rx_data;
                    2'd2:    r_field[23:16] <= rx_data;
                    default: r_field        <= r_field;
                endcase
            end
            if (w_last) begin
                case (r_state)
                    S_LEN: begin
                        r_len <= w_word;
`ifdef CHECKSUM_EN
                        r_csum <= 32'd0;
`endif
                    end
                    S_ADR:  mem_adr <= w_word[AW-1:0];
                    S_DATA: begin
                        mem_wdata <= w_word;
`ifdef CHECKSUM_EN
                        r_csum <= r_csum + w_word;
`endif
                    end
                    default: ;
                endcase
            end
            if ((r_state == S_WRITE) && mem_ready) begin
                mem_adr <= mem_adr + c_ADR_ONE;
                r_len   <= r_len - 32'd1;
            end
            // Busy stays up between blocks and drops only on a terminal state
            if ((w_next == S_DONE) || (w_next == S_ERR)) r_busy <= 1'b0;
            else if (w_accept)                           r_busy <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Randomised self-checking bench for mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [31:0]   mem_wdata;
    logic          mem_ready = 1'b0;
    logic          busy, done, err;

    mem_loader #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int stall_cycles = 0;
    int wcnt = 0;
    logic [AW-1:0] h_adr;
    logic [31:0]   h_dat;

    logic [7:0]       stream_q[$];
    logic [AW+31:0]   exp_q[$];
    logic [AW+31:0]   obs_q[$];
    logic [31:0]      blk_w[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM write-port responder: stalls each write, records accepted writes
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (wcnt == 0) begin
                h_adr = mem_adr;
                h_dat = mem_wdata;
            end else begin
                check("stall_adr_stable", 64'(mem_adr), 64'(h_adr));
                check("stall_dat_stable", 64'(mem_wdata), 64'(h_dat));
            end
            if (wcnt >= stall_cycles) begin
                mem_ready = 1'b1;
                obs_q.push_back({mem_adr, mem_wdata});
            end else begin
                mem_ready = 1'b0;
            end
            wcnt++;
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    task automatic push32(input logic [31:0] v);
        for (int k = 0; k < 4; k++) stream_q.push_back(8'((v >> (8 * k)) & 32'hFF));
    endtask

    // Reference block: expected writes are ADR+i modulo memory size
    task automatic add_block(input logic [31:0] adr);
        logic [31:0] sum = 32'd0;
        push32(32'(blk_w.size()));
        push32(adr);
        for (int i = 0; i < blk_w.size(); i++) begin
            logic [31:0] a = (adr + 32'(i)) % (32'd1 << AW);
            push32(blk_w[i]);
            exp_q.push_back({a[AW-1:0], blk_w[i]});
            sum = sum + blk_w[i];
        end
`ifdef CHECKSUM_EN
        push32(sum);
`endif
        blk_w.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("rx_ready_timeout", 64'(t), 64'd0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_adr", 64'(mem_adr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_rx_ready", 64'(rx_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        obs_q.delete();
    endtask

    task automatic run_stream(input int gmax, input int stall, input bit exp_err, input bit chk_lat);
        int t = 0;
        stall_cycles = stall;
        for (int k = 0; k < stream_q.size(); k++) begin
            send_byte(stream_q[k], (gmax == 0) ? 0 : int'($urandom_range(gmax, 0)));
            if (k == 0) check("busy_after_first", 64'(busy), 64'd1);
            if (chk_lat && k == 11) begin
                check("lat_mem_we", 64'(mem_we), 64'd1);
                check("lat_rx_ready", 64'(rx_ready), 64'd0);
            end
        end
        while (!(done || err) && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("term_done", 64'(done), exp_err ? 64'd0 : 64'd1);
        check("term_err", 64'(err), exp_err ? 64'd1 : 64'd0);
        check("term_rx_ready", 64'(rx_ready), 64'd0);
        check("term_busy", 64'(busy), 64'd0);
        check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("write_adr_data", 64'(obs_q[i]), 64'(exp_q[i]));
        stream_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        #1;
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_outputs", 64'({busy, done, err}), 64'd0);
        @(negedge clk);
        do_reset();

        // Basic block, no gaps or stalls
        blk_w.push_back(32'h11223344);
        blk_w.push_back(32'hAABBCCDD);
        add_block(32'h10);
        push32(32'd0);
        run_stream(0, 0, 1'b0, 1'b1);

        // Same stream with rx gaps and 3-cycle write stalls
        do_reset();
        blk_w.push_back(32'h11223344);
        blk_w.push_back(32'hAABBCCDD);
        add_block(32'h10);
        push32(32'd0);
        run_stream(5, 3, 1'b0, 1'b0);

        // Address wrap at top of memory
        do_reset();
        for (int i = 0; i < 3; i++) blk_w.push_back($urandom);
        add_block(32'h1FF);
        push32(32'd0);
        run_stream(2, 1, 1'b0, 1'b0);

        // Upper address bits ignored
        do_reset();
        for (int i = 0; i < 2; i++) blk_w.push_back($urandom);
        add_block(32'hFFFF0020);
        push32(32'd0);
        run_stream(1, 2, 1'b0, 1'b0);

        // Reset mid-block after the 2nd byte of the 2nd data word
        do_reset();
        blk_w.push_back(32'hDEADBEEF);
        blk_w.push_back(32'hCAFEF00D);
        add_block(32'h40);
        stall_cycles = 0;
        for (int k = 0; k < 14; k++) send_byte(stream_q[k], 0);
        stream_q.delete();
        exp_q.delete();
        do_reset();
        check("no_write_in_reset", 64'(obs_q.size()), 64'd0);
        blk_w.push_back(32'h01020304);
        add_block(32'h80);
        push32(32'd0);
        run_stream(3, 2, 1'b0, 1'b0);

        // Several random blocks
        do_reset();
        for (int b = 0; b < 3; b++) begin
            int n = int'($urandom_range(4, 1));
            for (int i = 0; i < n; i++) blk_w.push_back($urandom);
            add_block($urandom);
        end
        push32(32'd0);
        run_stream(4, int'($urandom_range(3, 0)), 1'b0, 1'b0);

`ifdef CHECKSUM_EN
        // Matching checksum, then a further block is accepted
        do_reset();
        blk_w.push_back(32'h00000005);
        add_block(32'h30);
        blk_w.push_back($urandom);
        add_block(32'h31);
        push32(32'd0);
        run_stream(1, 1, 1'b0, 1'b0);

        // Mismatching checksum goes to error
        do_reset();
        push32(32'd1);
        push32(32'h30);
        push32(32'h00000005);
        push32(32'h00000006);
        exp_q.push_back({9'h030, 32'h00000005});
        run_stream(1, 0, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
